// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared glyphs, sign-magnitude fields and display mode encoding
//
// Provides the active-low {g,f,e,d,c,b,a} glyph constants, the bit positions
// of the 4-bit sign-magnitude result, and the BLANK/SHOW mode type.
package calc_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam int SIGN_BIT = 3;
    localparam int MAG_MSB  = 2;

    typedef enum logic {
        MODE_BLANK = 1'b0,
        MODE_SHOW  = 1'b1
    } mode_t;

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - 3-bit magnitude to active-low seven-segment glyph
//
// Ports:
//   mag   - magnitude 0..7
//   glyph - {g,f,e,d,c,b,a}, active-low
module seg7_glyph
    import calc_pkg::*;
(
    input  logic [2:0] mag,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        case (mag)
            3'd0: glyph = GLYPH_0;
            3'd1: glyph = GLYPH_1;
            3'd2: glyph = GLYPH_2;
            3'd3: glyph = GLYPH_3;
            3'd4: glyph = GLYPH_4;
            3'd5: glyph = GLYPH_5;
            3'd6: glyph = GLYPH_6;
            3'd7: glyph = GLYPH_7;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display.sv
// rtl/calc_display.sv - two-digit multiplexed seven-segment driver for the signed result
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - single-cycle capture strobe for result/err
//   result     - sign-magnitude value (bit 3 sign, bits 2:0 magnitude)
//   err        - show "Er" instead of a value
//   seg        - registered active-low segments {g,f,e,d,c,b,a}
//   an         - registered active-low digit enables (an[0] magnitude, an[1] sign)
//   shown      - a value or error has been captured since reset
module calc_display
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] result,
    input  logic       err,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       shown
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic [3:0]       val_q;
    logic             err_q;
    mode_t            mode_q;
    mode_t            mode_d;
    logic [6:0]       mag_glyph;
    logic [6:0]       sign_glyph;
    logic [6:0]       seg_d;
    logic [1:0]       an_d;

    seg7_glyph u_glyph (
        .mag   (val_q[MAG_MSB:0]),
        .glyph (mag_glyph)
    );

    // Refresh counter and digit select run from reset regardless of load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            sel <= ~sel;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            err_q <= 1'b0;
        end else if (load) begin
            val_q <= result;
            err_q <= err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BLANK;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Only reset leaves SHOW, so the first load is the only transition.
    always_comb begin
        mode_d = mode_q;
        if (load) begin
            mode_d = MODE_SHOW;
        end
    end

    // Negative zero is suppressed so that 4'b1000 reads exactly like +0.
    always_comb begin
        sign_glyph = GLYPH_BLANK;
        if (err_q) begin
            sign_glyph = GLYPH_E;
        end else if (val_q[SIGN_BIT] && (val_q[MAG_MSB:0] != '0)) begin
            sign_glyph = GLYPH_MINUS;
        end
    end

    // The cnt==0 cycle of each slot blanks both digits to avoid ghosting
    // while the anode switches.
    always_comb begin
        seg_d = GLYPH_BLANK;
        an_d  = 2'b11;
        if (mode_q == MODE_SHOW && cnt != '0) begin
            if (sel) begin
                an_d  = 2'b01;
                seg_d = sign_glyph;
            end else begin
                an_d  = 2'b10;
                seg_d = err_q ? GLYPH_R : mag_glyph;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= GLYPH_BLANK;
            an  <= 2'b11;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

    assign shown = (mode_q == MODE_SHOW);

endmodule

// File: tb/tb_calc_display.sv
// tb/tb_calc_display.sv - scoreboard bench for calc_display with a frame-arithmetic model
module tb_calc_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] result = 4'd0;
    logic       err = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       shown;

    calc_display #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .result (result),
        .err    (err),
        .seg    (seg),
        .an     (an),
        .shown  (shown)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       shown;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model state: edges since reset release, and the captured value.
    int         e = 0;
    logic [3:0] m_val = 4'd0;
    logic       m_err = 1'b0;
    logic       m_shown = 1'b0;

    logic [6:0] digit_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    // Display after edge ee+1, from the state that held after edge ee.
    function automatic exp_t model_out(int ee, logic [3:0] v, logic er, logic sh);
        exp_t o;
        o.seg   = 7'h7F;
        o.an    = 2'b11;
        o.shown = sh;
        if (sh && (ee % 4) != 0) begin
            if (((ee / 4) % 2) == 1) begin
                o.an  = 2'b01;
                o.seg = er ? 7'b0000110 :
                        ((v[3] && v[2:0] != 3'd0) ? 7'b0111111 : 7'b1111111);
            end else begin
                o.an  = 2'b10;
                o.seg = er ? 7'b0101111 : digit_tab[v[2:0]];
            end
        end
        return o;
    endfunction

    // Called at a negedge: drive inputs for the next edge and push the
    // expected outputs after that edge.
    task automatic step(input logic ld, input logic [3:0] r, input logic er);
        exp_t x;
        load   = ld;
        result = r;
        err    = er;
        x = model_out(e, m_val, m_err, m_shown);
        x.shown = m_shown | ld;
        q.push_back(x);
        if (ld) begin
            m_val   = r;
            m_err   = er;
            m_shown = 1'b1;
        end
        e++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
    endtask

    task automatic check_reset_state(input string name);
        tests++;
        if (seg !== 7'h7F || an !== 2'b11 || shown !== 1'b0) begin
            fails++;
            $display("FAIL %s: seg=%b an=%b shown=%b, want seg=1111111 an=11 shown=0",
                     name, seg, an, shown);
        end
    endtask

    // Asserted mid-low-phase, away from any edge; outputs must clear at once.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        check_reset_state("async_reset");
        q.delete();
        e       = 0;
        m_val   = 4'd0;
        m_err   = 1'b0;
        m_shown = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (rst_n && q.size() > 0) begin
            x = q.pop_front();
            tests++;
            if (seg !== x.seg || an !== x.an || shown !== x.shown) begin
                fails++;
                $display("FAIL display t=%0t: seg=%b an=%b shown=%b, want seg=%b an=%b shown=%b",
                         $time, seg, an, shown, x.seg, x.an, x.shown);
            end
        end
    end

    initial begin
        @(negedge clk);
        check_reset_state("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        idle(20);
        step(1'b1, 4'b0101, 1'b0);
        idle(10);
        step(1'b1, 4'b1011, 1'b0);
        idle(9);
        step(1'b1, 4'b1000, 1'b0);
        idle(9);
        step(1'b1, 4'b0011, 1'b1);
        idle(9);
        step(1'b1, 4'b0001, 1'b0);
        idle(9);

        while ((e % 4) != 3) step(1'b0, 4'd0, 1'b0);
        step(1'b1, 4'b1100, 1'b0);
        idle(6);
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b0110, 1'b0);
        idle(10);

        step(1'b1, 4'b1111, 1'b0);
        idle(9);
        pulse_reset();
        idle(12);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 7) == 0));
            end
        end
        idle(4);

        @(posedge clk);
        #3;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
